// File: rtl/vcdl_fb_scanner.sv
// vcdl_fb_scanner: sweeps the VCDL IDELAY tap from 0 to 31 and locks on the
// first tap where the synchronized feedback moves from mostly-0 to mostly-1.
// At each tap the scanner waits SETTLE cycles, counts ones over SAMPLES cycles,
// then classifies the tap. It ends with a final load of the edge tap, or of 0
// when no edge was found.
// Optional feature: define VCDL_SCAN_HYST_EN to classify with a hysteresis band
// (>=3/4 is one, <=1/4 is zero, in between keeps the previous class) instead of
// a simple majority vote.
module vcdl_fb_scanner #(
  parameter int SAMPLES = 64,
  parameter int SETTLE  = 16
) (
  input  logic       sysclk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       vcdl_fb_q_i,
  output logic [4:0] delay_o,
  output logic       load_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       locked_o,
  output logic [4:0] edge_tap_o
);

  localparam int CW = $clog2(SAMPLES) + 1;
  localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [CW-1:0] SAMPLE_LAST = CW'(SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_EVAL,
    S_FINAL
  } state_t;

  state_t        state, state_nxt;
  logic [4:0]    tap, tap_nxt;
  logic [7:0]    settle_cnt, settle_nxt;
  logic [CW-1:0] sample_cnt, sample_nxt;
  logic [CW-1:0] ones, ones_nxt;
  logic          prev_class, prev_nxt;
  logic          cur_class;
  logic [4:0]    delay_nxt, edge_nxt;
  logic          load_nxt, done_nxt, locked_nxt;
  logic          sync_meta, sync_q;

  // Two-flop synchronizer for the feedback sample, which is asynchronous to sysclk.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= vcdl_fb_q_i;
      sync_q    <= sync_meta;
    end
  end

`ifdef VCDL_SCAN_HYST_EN
  localparam logic [CW-1:0] HI_TH = CW'((3 * SAMPLES) / 4);
  localparam logic [CW-1:0] LO_TH = CW'(SAMPLES / 4);

  // Hysteresis classification; an ambiguous count keeps the previous class (0 at tap 0).
  always_comb begin
    cur_class = (tap == 5'd0) ? 1'b0 : prev_class;
    if (ones >= HI_TH) begin
      cur_class = 1'b1;
    end else if (ones <= LO_TH) begin
      cur_class = 1'b0;
    end
  end
`else
  localparam logic [CW-1:0] HALF = CW'(SAMPLES / 2);

  // Majority classification: strictly more than half the samples high means one.
  always_comb begin
    cur_class = 1'b0;
    if (ones > HALF) begin
      cur_class = 1'b1;
    end
  end
`endif

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_nxt  = state;
    tap_nxt    = tap;
    settle_nxt = settle_cnt;
    sample_nxt = sample_cnt;
    ones_nxt   = ones;
    prev_nxt   = prev_class;
    delay_nxt  = delay_o;
    edge_nxt   = edge_tap_o;
    locked_nxt = locked_o;
    load_nxt   = 1'b0;
    done_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_nxt  = S_LOAD;
          tap_nxt    = 5'd0;
          prev_nxt   = 1'b0;
          locked_nxt = 1'b0;
          edge_nxt   = 5'd0;
          load_nxt   = 1'b1;
          delay_nxt  = 5'd0;
        end
      end
      S_LOAD: begin
        state_nxt  = S_SETTLE;
        settle_nxt = 8'd0;
      end
      S_SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt  = S_SAMPLE;
          ones_nxt   = '0;
          sample_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + 8'd1;
        end
      end
      S_SAMPLE: begin
        ones_nxt = ones + {{(CW-1){1'b0}}, sync_q};
        if (sample_cnt == SAMPLE_LAST) begin
          state_nxt = S_EVAL;
        end else begin
          sample_nxt = sample_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      S_EVAL: begin
        if ((tap != 5'd0) && !prev_class && cur_class) begin
          state_nxt  = S_FINAL;
          edge_nxt   = tap;
          locked_nxt = 1'b1;
          load_nxt   = 1'b1;
          done_nxt   = 1'b1;
          delay_nxt  = tap;
        end else if (tap != 5'd31) begin
          state_nxt = S_LOAD;
          prev_nxt  = cur_class;
          tap_nxt   = tap + 5'd1;
          load_nxt  = 1'b1;
          delay_nxt = tap + 5'd1;
        end else begin
          state_nxt  = S_FINAL;
          edge_nxt   = 5'd0;
          locked_nxt = 1'b0;
          load_nxt   = 1'b1;
          done_nxt   = 1'b1;
          delay_nxt  = 5'd0;
        end
      end
      S_FINAL: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any scan immediately.
  always_ff @(posedge sysclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= S_IDLE;
      tap        <= 5'd0;
      settle_cnt <= 8'd0;
      sample_cnt <= '0;
      ones       <= '0;
      prev_class <= 1'b0;
      delay_o    <= 5'd0;
      load_o     <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      locked_o   <= 1'b0;
      edge_tap_o <= 5'd0;
    end else begin
      state      <= state_nxt;
      tap        <= tap_nxt;
      settle_cnt <= settle_nxt;
      sample_cnt <= sample_nxt;
      ones       <= ones_nxt;
      prev_class <= prev_nxt;
      delay_o    <= delay_nxt;
      load_o     <= load_nxt;
      busy_o     <= (state_nxt != S_IDLE);
      done_o     <= done_nxt;
      locked_o   <= locked_nxt;
      edge_tap_o <= edge_nxt;
    end
  end

endmodule

// File: tb/tb_vcdl_fb_scanner.sv
// tb_vcdl_fb_scanner: drives per-tap feedback patterns into the scanner and
// compares every scan against a reference model that applies the tap
// classification and edge rules directly to the ones counted per tap.
module tb_vcdl_fb_scanner;

  localparam int SAMPLES = 64;
  localparam int SETTLE  = 16;
  localparam int PERIOD  = SETTLE + SAMPLES + 2;

  logic       sysclk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       start_i = 1'b0;
  logic       vcdl_fb_q_i = 1'b0;
  logic [4:0] delay_o;
  logic       load_o;
  logic       busy_o;
  logic       done_o;
  logic       locked_o;
  logic [4:0] edge_tap_o;

  vcdl_fb_scanner #(.SAMPLES(SAMPLES), .SETTLE(SETTLE)) dut (
    .sysclk_i   (sysclk_i),
    .rst_n_i    (rst_n_i),
    .start_i    (start_i),
    .vcdl_fb_q_i(vcdl_fb_q_i),
    .delay_o    (delay_o),
    .load_o     (load_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .locked_o   (locked_o),
    .edge_tap_o (edge_tap_o)
  );

  always #5 sysclk_i = ~sysclk_i;

  int checks = 0;
  int errors = 0;

  // Feedback bit per tap, indexed by cycles since that tap's load strobe.
  logic [81:0] pat [32];

  int exp_locked;
  int exp_edge;
  int exp_taps;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Noisy taps: 60% ones in the middle, held at 1 near both ends of the tap
  // period so the synchronizer skew cannot change the counted total.
  function automatic logic [81:0] noisy_bits();
    logic [81:0] b;
    b = '1;
    for (int j = 21; j <= 70; j++) b[j] = ($urandom_range(99) < 60);
    return b;
  endfunction

  function automatic int window_ones(input logic [81:0] p);
    int s;
    s = 0;
    for (int j = 15; j <= 78; j++) s += int'(p[j]);
    return s;
  endfunction

  function automatic int classify(input int ones, input int prev, input int tap);
`ifdef VCDL_SCAN_HYST_EN
    if (ones * 4 >= 3 * SAMPLES) return 1;
    if (ones * 4 <= SAMPLES) return 0;
    return (tap == 0) ? 0 : prev;
`else
    if (tap < 0) return prev;
    return (ones * 2 > SAMPLES) ? 1 : 0;
`endif
  endfunction

  // Reference scan: walk taps, stop at the first 0 -> 1 class transition after tap 0.
  task automatic predict();
    int prev;
    int c;
    exp_locked = 0;
    exp_edge   = 0;
    exp_taps   = 32;
    prev       = 0;
    for (int t = 0; t < 32; t++) begin
      c = classify(window_ones(pat[t]), prev, t);
      if (t > 0 && prev == 0 && c == 1) begin
        exp_locked = 1;
        exp_edge   = t;
        exp_taps   = t + 1;
        break;
      end
      prev = c;
    end
  endtask

  // mode 0: 1 from tap thr; 1: stuck 0; 2: 1 for taps 0..4 only;
  // 3: noisy at taps 7..8, 0 below, 1 above; 4: random mix per tap.
  task automatic build_pattern(input int mode, input int thr);
    int r;
    for (int t = 0; t < 32; t++) begin
      case (mode)
        0: pat[t] = (t >= thr) ? '1 : '0;
        1: pat[t] = '0;
        2: pat[t] = (t <= 4) ? '1 : '0;
        3: pat[t] = (t < 7) ? '0 : ((t <= 8) ? noisy_bits() : '1);
        default: begin
          r = int'($urandom_range(9));
          if (r < 4) pat[t] = '0;
          else if (r < 8) pat[t] = '1;
          else pat[t] = noisy_bits();
        end
      endcase
    end
  endtask

  // VCDL feedback model: follows the last tap loaded by the scanner.
  initial begin
    int cur_tap;
    int j;
    cur_tap = 0;
    j = 81;
    forever begin
      @(negedge sysclk_i);
      if (load_o) begin
        cur_tap = int'(delay_o);
        j = 0;
      end else if (j < 81) begin
        j++;
      end
      vcdl_fb_q_i = pat[cur_tap][j];
    end
  end

  // Run one scan, checking every load strobe, the completion cycle and the held results.
  task automatic applyStimulus(input int pulse_extra);
    int cycles;
    int loads;
    int dones;
    int done_cycle;
    predict();
    @(negedge sysclk_i);
    start_i = 1'b1;
    @(negedge sysclk_i);
    start_i = 1'b0;
    cycles = 1;
    loads = 0;
    dones = 0;
    done_cycle = -1;
    while (cycles <= 32 * PERIOD + 300) begin
      start_i = (pulse_extra != 0) && (cycles == 100 || cycles == 3 * PERIOD + 7);
      if (cycles == 1) checkOutput("lock_clear", int'(locked_o), 0);
      if (cycles == 50) checkOutput("busy_mid", int'(busy_o), 1);
      if (done_o) begin
        dones++;
        if (done_cycle < 0) begin
          done_cycle = cycles;
          checkOutput("done_latency", cycles, exp_taps * PERIOD + 1);
          checkOutput("final_load", int'(load_o), 1);
          checkOutput("final_delay", int'(delay_o), exp_edge);
          checkOutput("final_locked", int'(locked_o), exp_locked);
          checkOutput("final_edge", int'(edge_tap_o), exp_edge);
        end
      end else if (load_o) begin
        checkOutput("load_tap", int'(delay_o), loads);
        loads++;
      end
      if (done_cycle >= 0 && cycles >= done_cycle + 150) break;
      @(negedge sysclk_i);
      cycles++;
    end
    start_i = 1'b0;
    if (done_cycle < 0) begin
      checkOutput("done_timeout", 0, 1);
    end else begin
      checkOutput("done_count", dones, 1);
      checkOutput("load_count", loads, exp_taps);
      checkOutput("busy_after", int'(busy_o), 0);
      checkOutput("locked_hold", int'(locked_o), exp_locked);
      checkOutput("edge_hold", int'(edge_tap_o), exp_edge);
    end
  endtask

  // Abort a scan with reset during the sampling phase of tap 6, then rescan.
  task automatic reset_mid_scan();
    int found;
    int stray;
    build_pattern(0, 10);
    @(negedge sysclk_i);
    start_i = 1'b1;
    @(negedge sysclk_i);
    start_i = 1'b0;
    found = 0;
    for (int c = 0; c < 7 * PERIOD + 10; c++) begin
      if (load_o && delay_o == 5'd6) begin
        found = 1;
        break;
      end
      @(negedge sysclk_i);
    end
    if (found == 0) checkOutput("tap6_timeout", 0, 1);
    repeat (30) @(negedge sysclk_i);
    #1 rst_n_i = 1'b0;
    #1;
    checkOutput("rst_delay", int'(delay_o), 0);
    checkOutput("rst_load", int'(load_o), 0);
    checkOutput("rst_busy", int'(busy_o), 0);
    checkOutput("rst_done", int'(done_o), 0);
    checkOutput("rst_locked", int'(locked_o), 0);
    checkOutput("rst_edge", int'(edge_tap_o), 0);
    repeat (3) @(negedge sysclk_i);
    rst_n_i = 1'b1;
    stray = 0;
    repeat (150) begin
      @(negedge sysclk_i);
      if (load_o || busy_o || done_o) stray++;
    end
    checkOutput("idle_after_reset", stray, 0);
    applyStimulus(0);
  endtask

  initial begin
    for (int t = 0; t < 32; t++) pat[t] = '0;
    rst_n_i = 1'b0;
    repeat (3) @(negedge sysclk_i);
    checkOutput("reset_delay", int'(delay_o), 0);
    checkOutput("reset_load", int'(load_o), 0);
    checkOutput("reset_busy", int'(busy_o), 0);
    checkOutput("reset_done", int'(done_o), 0);
    checkOutput("reset_locked", int'(locked_o), 0);
    checkOutput("reset_edge", int'(edge_tap_o), 0);
    rst_n_i = 1'b1;
    repeat (5) @(negedge sysclk_i);

    $display("[TB] clean edge at tap 10, with extra start pulses while busy");
    build_pattern(0, 10);
    applyStimulus(1);

    $display("[TB] feedback stuck at 0");
    build_pattern(1, 0);
    applyStimulus(0);

    $display("[TB] falling edge only, at tap 5");
    build_pattern(2, 0);
    applyStimulus(0);

    $display("[TB] noisy taps 7..8");
    build_pattern(3, 0);
    applyStimulus(0);

    $display("[TB] reset during sampling at tap 6");
    reset_mid_scan();

    for (int i = 0; i < 3; i++) begin
      $display("[TB] random pattern %0d", i);
      build_pattern(4, 0);
      applyStimulus(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
